// File: rtl/udma_i2c_pkg.sv
// Shared I2C command codes and command-stream parser states for the uDMA I2C arbiter and control.
package udma_i2c_pkg;

    localparam logic [3:0] I2C_CMD_START   = 4'h0;
    localparam logic [3:0] I2C_CMD_WAIT_EV = 4'h1;
    localparam logic [3:0] I2C_CMD_STOP    = 4'h2;
    localparam logic [3:0] I2C_CMD_RD_ACK  = 4'h4;
    localparam logic [3:0] I2C_CMD_RD_NACK = 4'h6;
    localparam logic [3:0] I2C_CMD_WR      = 4'h8;
    localparam logic [3:0] I2C_CMD_EOT     = 4'h9;
    localparam logic [3:0] I2C_CMD_WAIT    = 4'hA;
    localparam logic [3:0] I2C_CMD_RPT     = 4'hC;
    localparam logic [3:0] I2C_CMD_CFG     = 4'hE;

    typedef enum logic [2:0] {
        I2C_ST_IDLE,
        I2C_ST_CMD,
        I2C_ST_ARG1,
        I2C_ST_CFG_MSB,
        I2C_ST_CFG_LSB,
        I2C_ST_DATA,
        I2C_ST_SKIP
    } i2c_parse_state_e;

endpackage

// File: rtl/udma_i2c_rr_arb.sv
// Pointer-based round-robin arbiter: combinational pick from the pointer upward, pointer moves past each accepted winner.
module udma_i2c_rr_arb #(
    parameter int NB_REQ = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NB_REQ-1:0] req,
    input  logic              advance,
    output logic [NB_REQ-1:0] grant,
    output logic [1:0]        grant_idx,
    output logic              found
);

    logic [1:0] ptr;

    // First pass covers indices at or above the pointer, second pass wraps to those below it.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            if (!found && req[i] && (i >= 32'(ptr))) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = i[1:0];
            end
        end
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            if (!found && req[i] && (i < 32'(ptr))) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = i[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (32'(grant_idx) == NB_REQ - 1) ? '0 : grant_idx + 2'd1;
        end
    end

endmodule

// File: rtl/udma_i2c_cmd_arb.sv
// Arbitrates several I2C command streams onto one I2C control; the grant is held until STOP/EOT is parsed.
// Optional idle-timeout release is enabled by defining UDMA_I2C_ARB_TIMEOUT_EN.
module udma_i2c_cmd_arb
    import udma_i2c_pkg::*;
#(
    parameter int NB_REQ      = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NB_REQ*8-1:0] req_data_i,
    input  logic [NB_REQ-1:0]   req_valid_i,
    output logic [NB_REQ-1:0]   req_ready_o,
    output logic [NB_REQ*8-1:0] rsp_data_o,
    output logic [NB_REQ-1:0]   rsp_valid_o,
    input  logic [NB_REQ-1:0]   rsp_ready_i,
    output logic [7:0]          cmd_data_o,
    output logic                cmd_valid_o,
    input  logic                cmd_ready_i,
    input  logic [7:0]          rx_data_i,
    input  logic                rx_valid_i,
    output logic                rx_ready_o,
    output logic [NB_REQ-1:0]   gnt_o,
    output logic                busy_o,
    output logic                timeout_o
);

    i2c_parse_state_e  state;
    logic [NB_REQ-1:0] gnt;
    logic              busy;
    logic [1:0]        owner;
    logic [1:0]        last_owner;
    logic [1:0]        rsp_sel;
    logic [7:0]        rpt;
    logic [7:0]        count;
    logic              arg_rpt;
    logic              hs;
    logic [NB_REQ-1:0] arb_grant;
    logic [1:0]        arb_idx;
    logic              arb_found;
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
    logic [31:0]       idle_cnt;
    logic              timeout_pulse;
`endif

    udma_i2c_rr_arb #(
        .NB_REQ(NB_REQ)
    ) u_arb (
        .clk      (clk_i),
        .rst      (rst_i),
        .req      (req_valid_i),
        .advance  (!busy),
        .grant    (arb_grant),
        .grant_idx(arb_idx),
        .found    (arb_found)
    );

    // Owner stream passes straight through; responses follow the last owner once released.
    always_comb begin
        cmd_data_o  = '0;
        cmd_valid_o = 1'b0;
        req_ready_o = '0;
        rsp_data_o  = '0;
        rsp_valid_o = '0;
        rx_ready_o  = 1'b0;
        rsp_sel     = busy ? owner : last_owner;
        for (int unsigned i = 0; i < NB_REQ; i++) begin
            if (busy && !rst_i && (owner == i[1:0])) begin
                cmd_data_o     = req_data_i[i*8 +: 8];
                cmd_valid_o    = req_valid_i[i];
                req_ready_o[i] = cmd_ready_i;
            end
            if (rsp_sel == i[1:0]) begin
                rsp_data_o[i*8 +: 8] = rx_data_i;
                rsp_valid_o[i]       = rx_valid_i && !rst_i;
                rx_ready_o           = rsp_ready_i[i];
            end
        end
    end

    assign hs = cmd_valid_o && cmd_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= I2C_ST_IDLE;
            gnt        <= '0;
            busy       <= 1'b0;
            owner      <= '0;
            last_owner <= '0;
            rpt        <= '0;
            count      <= '0;
            arg_rpt    <= 1'b0;
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
            idle_cnt      <= '0;
            timeout_pulse <= 1'b0;
`endif
        end else begin
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
            timeout_pulse <= 1'b0;
`endif
            if (!busy) begin
                if (arb_found) begin
                    gnt        <= arb_grant;
                    busy       <= 1'b1;
                    owner      <= arb_idx;
                    last_owner <= arb_idx;
                    state      <= I2C_ST_CMD;
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
                    idle_cnt   <= '0;
`endif
                end
            end else if (hs) begin
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
                idle_cnt <= '0;
`endif
                unique case (state)
                    I2C_ST_CMD: begin
                        case (cmd_data_o[7:4])
                            I2C_CMD_WAIT: begin
                                arg_rpt <= 1'b0;
                                state   <= I2C_ST_ARG1;
                            end
                            I2C_CMD_RPT: begin
                                arg_rpt <= 1'b1;
                                state   <= I2C_ST_ARG1;
                            end
                            I2C_CMD_CFG: state <= I2C_ST_CFG_MSB;
                            I2C_CMD_WR: begin
                                count <= (rpt == 8'd0) ? 8'd1 : rpt;
                                state <= I2C_ST_DATA;
                            end
                            I2C_CMD_RD_ACK, I2C_CMD_RD_NACK: rpt <= '0;
                            I2C_CMD_STOP, I2C_CMD_EOT: begin
                                gnt   <= '0;
                                busy  <= 1'b0;
                                state <= I2C_ST_IDLE;
                            end
                            default: ;
                        endcase
                    end
                    I2C_ST_ARG1: begin
                        if (arg_rpt) begin
                            rpt   <= cmd_data_o;
                            state <= (cmd_data_o == 8'd0) ? I2C_ST_SKIP : I2C_ST_CMD;
                        end else begin
                            state <= I2C_ST_CMD;
                        end
                    end
                    I2C_ST_CFG_MSB: state <= I2C_ST_CFG_LSB;
                    I2C_ST_CFG_LSB: state <= I2C_ST_CMD;
                    I2C_ST_DATA: begin
                        if (count <= 8'd1) begin
                            rpt   <= '0;
                            state <= I2C_ST_CMD;
                        end else begin
                            count <= count - 8'd1;
                        end
                    end
                    I2C_ST_SKIP: state <= I2C_ST_CMD;
                    default: state <= I2C_ST_CMD;
                endcase
            end
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
            else if (idle_cnt == 32'(TIMEOUT_CYC - 1)) begin
                gnt           <= '0;
                busy          <= 1'b0;
                state         <= I2C_ST_IDLE;
                rpt           <= '0;
                idle_cnt      <= '0;
                timeout_pulse <= 1'b1;
            end else begin
                idle_cnt <= idle_cnt + 32'd1;
            end
`endif
        end
    end

    assign gnt_o  = gnt;
    assign busy_o = busy;
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
    assign timeout_o = timeout_pulse;
`else
    // Constant 0 for any legal TIMEOUT_CYC; without the timeout build the grant is never forced off.
    assign timeout_o = (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_udma_i2c_cmd_arb.sv
// Self-checking bench for udma_i2c_cmd_arb: transaction table, directed corner cases, randomized run against a model.
// Covers the UDMA_I2C_ARB_TIMEOUT_EN build when that macro is defined.
module tb_udma_i2c_cmd_arb;

    localparam int N  = 2;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_valid, req_ready_o;
    logic [N*8-1:0] rsp_data_o;
    logic [N-1:0]   rsp_valid_o, rsp_ready;
    logic [7:0]     cmd_data_o;
    logic           cmd_valid_o, cmd_ready;
    logic [7:0]     rx_data;
    logic           rx_valid, rx_ready_o;
    logic [N-1:0]   gnt_o;
    logic           busy_o, timeout_o;

    always #5 clk = ~clk;

    udma_i2c_cmd_arb #(.NB_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_data_i(req_data), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .rsp_data_o(rsp_data_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
        .cmd_data_o(cmd_data_o), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready_o),
        .gnt_o(gnt_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    logic [N-1:0] hs_seen;

    // Reference model: owner index (-1 = none), rr pointer, and a count of upcoming bytes that are not commands.
    bit m_init = 0;
    int m_own, m_ptr, m_last, m_opq, m_rpt, m_idle;
    bit m_arg, m_pulse;

    logic [7:0] codes [10] = '{8'h00, 8'h10, 8'h20, 8'h40, 8'h60, 8'h80, 8'h90, 8'hA0, 8'hC0, 8'hE0};

    typedef struct {
        string       name;
        int          r;
        int          n;
        logic [47:0] bytes;
        logic        held;
        logic [7:0]  rel;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    function automatic int pick_winner(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_check();
        logic [N-1:0] e_gnt, e_rdy, e_rsv;
        logic e_cv;
        int sel;
        if (!m_init) return;
        e_gnt = (m_own >= 0) ? N'(1 << m_own) : '0;
        e_cv  = (m_own >= 0) && !rst && req_valid[m_own];
        e_rdy = (m_own >= 0 && !rst && cmd_ready) ? N'(1 << m_own) : '0;
        sel   = (m_own >= 0) ? m_own : m_last;
        e_rsv = (rx_valid && !rst) ? N'(1 << sel) : '0;
        chk("gnt", 32'(gnt_o), 32'(e_gnt));
        chk("busy", 32'(busy_o), 32'(m_own >= 0));
        chk("cmd_valid", 32'(cmd_valid_o), 32'(e_cv));
        if (e_cv) chk("cmd_data", 32'(cmd_data_o), 32'(req_data[m_own*8 +: 8]));
        chk("req_ready", 32'(req_ready_o), 32'(e_rdy));
        chk("rsp_valid", 32'(rsp_valid_o), 32'(e_rsv));
        if (e_rsv != '0) chk("rsp_data", 32'(rsp_data_o[sel*8 +: 8]), 32'(rx_data));
        chk("rx_ready", 32'(rx_ready_o), 32'(rsp_ready[sel]));
        chk("timeout", 32'(timeout_o), 32'(m_pulse));
    endtask

    task automatic model_update();
        int w;
        logic [7:0] b;
        m_pulse = 0;
        if (rst) begin
            m_init = 1; m_own = -1; m_ptr = 0; m_last = 0;
            m_opq = 0; m_rpt = 0; m_arg = 0; m_idle = 0;
            return;
        end
        if (!m_init) return;
        if (m_own < 0) begin
            w = pick_winner(req_valid);
            if (w >= 0) begin
                m_own = w; m_last = w; m_ptr = (w + 1) % N;
                m_opq = 0; m_arg = 0; m_idle = 0;
            end
        end else if (req_valid[m_own] && cmd_ready) begin
            b = req_data[m_own*8 +: 8];
            m_idle = 0;
            if (m_arg) begin
                m_arg = 0; m_rpt = int'(b);
                if (b == 8'h00) m_opq = 1;
            end else if (m_opq > 0) begin
                m_opq--;
            end else begin
                case (b[7:4])
                    4'hA: m_opq = 1;
                    4'hC: m_arg = 1;
                    4'hE: m_opq = 2;
                    4'h8: begin m_opq = (m_rpt == 0) ? 1 : m_rpt; m_rpt = 0; end
                    4'h4, 4'h6: m_rpt = 0;
                    4'h2, 4'h9: m_own = -1;
                    default: ;
                endcase
            end
        end
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
        else begin
            m_idle++;
            if (m_idle == TO) begin
                m_own = -1; m_pulse = 1; m_rpt = 0; m_idle = 0;
            end
        end
`endif
    endtask

    // Entered just after a falling edge with inputs already driven.
    task automatic tick();
        #2;
        model_check();
        hs_seen = req_ready_o & req_valid;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic send(input int r, input logic [7:0] b);
        req_data[r*8 +: 8] = b;
        req_valid[r] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (hs_seen[r]) break;
        end
        chk("send_hs", 32'(hs_seen[r]), 32'd1);
        req_valid[r] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; rx_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic set_vec(input int i, input string name, input int r, input int n,
                           input logic [47:0] bytes, input logic held, input logic [7:0] rel);
        vecs[i].name = name; vecs[i].r = r; vecs[i].n = n;
        vecs[i].bytes = bytes; vecs[i].held = held; vecs[i].rel = rel;
    endtask

    function automatic logic [7:0] rand_byte();
        int unsigned s = $urandom_range(3, 0);
        if (s < 2) return codes[$urandom_range(9, 0)];
        if (s == 2) return 8'($urandom_range(3, 0));
        return 8'($urandom);
    endfunction

    initial begin
        logic [7:0] b;
        int owners[$];
        int k;

        set_vec(0, "wr_then_stop",   0, 4, 48'h0080A5200000, 1'b0, 8'h00);
        set_vec(1, "rpt_payload",    0, 6, 48'hC00380209020, 1'b1, 8'h20);
        set_vec(2, "cfg_payload",    0, 3, 48'hE02090000000, 1'b1, 8'h90);
        set_vec(3, "rpt0_skip",      1, 3, 48'hC00020000000, 1'b1, 8'h90);
        set_vec(4, "wait_arg",       0, 2, 48'hA02000000000, 1'b1, 8'h90);
        set_vec(5, "read_clears_rpt",0, 5, 48'hC00240802000, 1'b1, 8'h20);
        set_vec(6, "wait_ev_start",  1, 3, 48'h100090000000, 1'b0, 8'h00);
        set_vec(7, "rpt2_payload",   0, 5, 48'hC00280AA2000, 1'b1, 8'h20);
        set_vec(8, "unknown_code",   1, 2, 48'h7F2000000000, 1'b0, 8'h00);

        rst = 1'b1; req_data = '0; req_valid = '1; rsp_ready = '1;
        cmd_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'h5A;
        @(negedge clk);
        tick();
        #2;
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid_o), 32'd0);
        chk("rst_req_ready", 32'(req_ready_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        tick();
        rst = 1'b0; req_valid = '0; rx_valid = 1'b0;

        foreach (vecs[i]) begin
            for (int j = 0; j < vecs[i].n; j++) begin
                b = vecs[i].bytes[47 - 8*j -: 8];
                send(vecs[i].r, b);
            end
            chk(vecs[i].name, 32'(gnt_o), vecs[i].held ? 32'(1 << vecs[i].r) : 32'd0);
            if (vecs[i].held) begin
                send(vecs[i].r, vecs[i].rel);
                chk({vecs[i].name, "_rel"}, 32'(gnt_o), 32'd0);
            end
        end

        // Contender arrives one cycle late and must wait for STOP plus one idle cycle.
        do_reset();
        req_data[7:0] = 8'h00; req_valid[0] = 1'b1;
        tick();
        req_data[15:8] = 8'h90; req_valid[1] = 1'b1;
        send(0, 8'h00); send(0, 8'h80); send(0, 8'hA5); send(0, 8'h20);
        chk("contend_release", 32'(gnt_o), 32'd0);
        tick();
        chk("contend_next", 32'(gnt_o), 32'd2);
        send(1, 8'h90);
        chk("contend_done", 32'(gnt_o), 32'd0);

        // Two persistent requesters alternate.
        do_reset();
        req_data = {8'h90, 8'h90}; req_valid = '1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (gnt_o == 2'b01) owners.push_back(0);
            if (gnt_o == 2'b10) owners.push_back(1);
        end
        req_valid = '0;
        chk("alt_count", 32'(owners.size() >= 4), 32'd1);
        for (int c = 0; c < 4 && c < owners.size(); c++) chk("alt_order", 32'(owners[c]), 32'(c % 2));

        // Reset while in write payload.
        do_reset();
        send(0, 8'hC0); send(0, 8'h05); send(0, 8'h80); send(0, 8'h11);
        req_valid[0] = 1'b1; rx_valid = 1'b1; rst = 1'b1;
        #2;
        chk("midrst_cmd_valid", 32'(cmd_valid_o), 32'd0);
        chk("midrst_req_ready", 32'(req_ready_o), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        tick();
        chk("midrst_gnt", 32'(gnt_o), 32'd0);
        rst = 1'b0; req_valid = '0; rx_valid = 1'b0;
        send(0, 8'h90);
        chk("midrst_fresh_parse", 32'(gnt_o), 32'd0);

`ifdef UDMA_I2C_ARB_TIMEOUT_EN
        do_reset();
        send(0, 8'h00);
        req_data[15:8] = 8'h90; req_valid[1] = 1'b1;
        k = 0;
        while (!timeout_o && k < 40) begin
            tick();
            k++;
        end
        chk("to_delay", 32'(k), 32'd16);
        chk("to_gnt", 32'(gnt_o), 32'd0);
        tick();
        chk("to_regrant", 32'(gnt_o), 32'd2);
        chk("to_single_pulse", 32'(timeout_o), 32'd0);
        send(1, 8'h90);
`endif

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < N; r++) begin
                if ($urandom_range(2, 0) == 0) req_data[r*8 +: 8] = rand_byte();
            end
            req_valid = N'($urandom);
            cmd_ready = ($urandom_range(3, 0) != 0);
            rsp_ready = N'($urandom);
            rx_valid  = 1'($urandom);
            rx_data   = 8'($urandom);
            rst       = ($urandom_range(399, 0) == 0);
            tick();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
